group_scan_ctrl: RTL

Sequencing stage directly upstream of the 16-to-4 group-OR selector. On a start pulse it snapshots a 16-bit request word, drives it to the selector as four 4-bit groups, and steps the 2-bit selector through groups 0..3. It collects each group's OR result from the selector's outputs into a 4-bit flag register, then pulses done.

---
 rtl/group_scan_pkg.sv | 25 ++
 rtl/group_scan_ctrl_if.sv | 25 ++
 rtl/group_next_sel.sv | 30 +++
 rtl/group_scan_ctrl.sv | 102 ++++++++++
 4 files changed

// File: rtl/group_scan_pkg.sv
// Shared types and sizes for the group scan controller and its helpers.
// Groups are the four 4-bit nibbles of the 16-bit request snapshot.
package group_scan_pkg;

  localparam int unsigned GROUPS = 4;
  localparam int unsigned SEL_W  = 2;
  localparam int unsigned GRP_W  = 4;
  localparam int unsigned WORD_W = GROUPS * GRP_W;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_t;

  // One bit per group: set when that group's nibble has any bit set.
  function automatic logic [GROUPS-1:0] group_nz(input logic [WORD_W-1:0] w);
    logic [GROUPS-1:0] nz;
    for (int unsigned k = 0; k < GROUPS; k++) begin
      nz[k] = |w[k*GRP_W +: GRP_W];
    end
    return nz;
  endfunction

endpackage

// File: rtl/group_scan_ctrl_if.sv
// Handshake/data bundle between the scan requester, the scan controller and
// the 16-to-4 group-OR selector.
interface group_scan_ctrl_if;
  import group_scan_pkg::*;

  logic              start;
  logic [WORD_W-1:0] req_in;
  logic [GROUPS-1:0] y_in;
  logic [WORD_W-1:0] grp_data;
  logic [SEL_W-1:0]  sel;
  logic [GROUPS-1:0] flags;
  logic              busy;
  logic              done;

  modport master (
    output start, req_in, y_in,
    input  grp_data, sel, flags, busy, done
  );

  modport slave (
    input  start, req_in, y_in,
    output grp_data, sel, flags, busy, done
  );

endinterface

// File: rtl/group_next_sel.sv
// Priority search for the next group with a nonzero nibble.
// Only built with SKIP_EMPTY_EN; the default build has no use for it.
`ifdef SKIP_EMPTY_EN
module group_next_sel
  import group_scan_pkg::*;
(
  input  logic [WORD_W-1:0] snap,
  input  logic [SEL_W-1:0]  cur,
  input  logic              first,
  output logic [SEL_W-1:0]  nxt,
  output logic              valid
);

  logic [GROUPS-1:0] nz;
  assign nz = group_nz(snap);

  // Walk high to low so the lowest qualifying group is the last one written.
  always_comb begin
    nxt   = '0;
    valid = 1'b0;
    for (int unsigned i = 0; i < GROUPS; i++) begin
      if (nz[GROUPS-1-i] && (first || (SEL_W'(GROUPS-1-i) > cur))) begin
        nxt   = SEL_W'(GROUPS-1-i);
        valid = 1'b1;
      end
    end
  end

endmodule
`endif

// File: rtl/group_scan_ctrl.sv
// Snapshots a request word and steps the group-OR selector through its groups,
// collecting one OR flag per group. Optional SKIP_EMPTY_EN skips zero nibbles.
module group_scan_ctrl
  import group_scan_pkg::*;
#(
  parameter int unsigned DWELL = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  group_scan_ctrl_if.slave  bus
);

  localparam logic [3:0] LAST_CNT = 4'(DWELL - 1);

  state_t            state, state_nxt;
  logic [3:0]        cnt;
  logic              last;
  logic [WORD_W-1:0] grp_q;
  logic [SEL_W-1:0]  sel_q;
  logic [GROUPS-1:0] flags_q;
  logic [SEL_W-1:0]  sel_first, sel_step;
  logic              have_first, have_step;

  assign last = (cnt == LAST_CNT);

`ifdef SKIP_EMPTY_EN
  logic              first;
  logic [WORD_W-1:0] snap;
  logic [SEL_W-1:0]  nxt;
  logic              nxt_vld;

  // In IDLE the search runs on the incoming word so E0 can load the first group.
  assign first = (state == IDLE);
  assign snap  = first ? bus.req_in : grp_q;

  group_next_sel u_next_sel (
    .snap  (snap),
    .cur   (sel_q),
    .first (first),
    .nxt   (nxt),
    .valid (nxt_vld)
  );

  assign sel_first  = nxt;
  assign have_first = nxt_vld;
  assign sel_step   = nxt;
  assign have_step  = nxt_vld;
`else
  assign sel_first  = '0;
  assign have_first = 1'b1;
  assign sel_step   = sel_q + 1'b1;
  assign have_step  = (sel_q != SEL_W'(GROUPS - 1));
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (bus.start) state_nxt = have_first ? SCAN : DONE;
      SCAN: if (last && !have_step) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grp_q   <= '0;
      sel_q   <= '0;
      flags_q <= '0;
      cnt     <= '0;
    end else begin
      unique case (state)
        IDLE: if (bus.start) begin
          grp_q   <= bus.req_in;
          flags_q <= '0;
          sel_q   <= sel_first;
          cnt     <= '0;
        end
        SCAN: if (last) begin
          flags_q[sel_q] <= bus.y_in[sel_q];
          cnt            <= '0;
          if (have_step) sel_q <= sel_step;
        end else begin
          cnt <= cnt + 4'd1;
        end
        default: ;
      endcase
    end
  end

  assign bus.grp_data = grp_q;
  assign bus.sel      = sel_q;
  assign bus.flags    = flags_q;
  assign bus.busy     = (state == SCAN);
  assign bus.done     = (state == DONE);

endmodule
